// File: rtl/input_event_scheduler_pkg.sv
// Shared types and helpers for the input event scheduler and its arbiter.
package input_event_scheduler_pkg;

    typedef enum logic {StIdle, StOffer} sched_state_e;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after last_grant, wrapping.
module input_event_scheduler_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_grant_i,
    output logic [N-1:0]    gnt_onehot_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        cand         = '0;
        gnt_idx_o    = '0;
        gnt_valid_o  = 1'b0;
        gnt_onehot_o = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(last_grant_i) + k) % N);
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        if (gnt_valid_o) begin
            gnt_onehot_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/input_event_scheduler.sv
// Samples synchronised inputs on a prescaled tick, queues one event per channel and
// serialises pending events onto a valid/ready channel in round-robin order.
module input_event_scheduler
    import input_event_scheduler_pkg::*;
#(
    parameter int unsigned  N_INPUTS   = 4,
    parameter int unsigned  SAMPLE_DIV = 50000,
    localparam int unsigned IdxW       = idx_width(N_INPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] in_data,
    input  logic                evt_ready,
    input  logic                ovf_clr,
    output logic                evt_valid,
    output logic [IdxW-1:0]     evt_id,
    output logic                evt_rising,
    output logic                sample_tick,
    output logic [N_INPUTS-1:0] level,
    output logic [N_INPUTS-1:0] ovf
);

    localparam int unsigned    CntW     = $clog2(SAMPLE_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(SAMPLE_DIV - 1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(N_INPUTS - 1);

    logic [SYNC_STAGES-1:0][N_INPUTS-1:0] sync_q, sync_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N_INPUTS-1:0] level_q, level_d, pending_q, pending_d;
    logic [N_INPUTS-1:0] dir_q, dir_d, ovf_q, ovf_d;
    sched_state_e        state_q, state_d;
    logic [IdxW-1:0]     evt_id_q, evt_id_d, last_grant_q, last_grant_d;
    logic                evt_rising_q, evt_rising_d;

    logic [N_INPUTS-1:0] sync2, change, grant_clr, gnt_onehot;
    logic [IdxW-1:0]     gnt_idx;
    logic                gnt_valid;

    input_event_scheduler_rr_arbiter #(
        .N    (N_INPUTS),
        .IdxW (IdxW)
    ) u_arbiter (
        .req_i        (pending_q),
        .last_grant_i (last_grant_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    assign sync2       = sync_q[SYNC_STAGES-1];
    assign sample_tick = (cnt_q == CntMax);

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], in_data};
        cnt_d        = sample_tick ? '0 : cnt_q + 1'b1;
        change       = sample_tick ? (sync2 ^ level_q) : '0;
        level_d      = sample_tick ? sync2 : level_q;
        state_d      = state_q;
        evt_id_d     = evt_id_q;
        evt_rising_d = evt_rising_q;
        last_grant_d = last_grant_q;
        grant_clr    = '0;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    state_d      = StOffer;
                    evt_id_d     = gnt_idx;
                    evt_rising_d = dir_q[gnt_idx];
                    last_grant_d = gnt_idx;
                    grant_clr    = gnt_onehot;
                end
            end
            StOffer: begin
                if (evt_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A change landing on its own grant edge is a fresh event, so it re-arms without ovf.
        pending_d = (pending_q & ~grant_clr) | change;
        dir_d     = (dir_q & ~change) | (sync2 & change);
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (change & pending_q & ~grant_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            pending_q    <= '0;
            dir_q        <= '0;
            ovf_q        <= '0;
            state_q      <= StIdle;
            evt_id_q     <= '0;
            evt_rising_q <= 1'b0;
            last_grant_q <= LastRst;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            pending_q    <= pending_d;
            dir_q        <= dir_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            evt_id_q     <= evt_id_d;
            evt_rising_q <= evt_rising_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign evt_valid  = (state_q == StOffer);
    assign evt_id     = evt_id_q;
    assign evt_rising = evt_rising_q;
    assign level      = level_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Bench for input_event_scheduler: vector table, directed corner cases and a random run
// against an event-level reference model.
module tb_input_event_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid, evt_rising, sample_tick;
    logic [1:0] evt_id;
    logic [3:0] level, ovf;

    always #5 clk = ~clk;

    input_event_scheduler #(
        .N_INPUTS   (N),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_rising  (evt_rising),
        .sample_tick (sample_tick),
        .level       (level),
        .ovf         (ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int id;
        bit rise;
    } ev_t;

    typedef struct {
        logic [3:0] din;
        logic       rdy;
        logic       tick;
        logic       valid;
        logic [1:0] id;
        logic       rise;
        logic [3:0] lvl;
    } vec_t;

    // Reference model: input history, edge count since reset, per-channel event bookkeeping.
    logic [3:0] m_h0, m_h1, m_level, m_pend, m_dir, m_ovf;
    int         m_k, m_id, m_last;
    bit         m_offer, m_rise;

    ev_t obs[$];
    bit  last_valid;
    int  last_id;
    bit  last_rise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_h0 = '0; m_h1 = '0; m_level = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
        m_k = 0; m_id = 0; m_last = N - 1; m_offer = 0; m_rise = 0;
        last_valid = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s2, pend_old;
        int g;
        bit tick;
        tick = (m_k % DIV) == DIV - 1;
        s2 = m_h1;
        pend_old = m_pend;
        g = -1;
        if (m_offer) begin
            if (evt_ready) m_offer = 0;
        end else begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_last + j) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                m_offer = 1; m_id = g; m_rise = m_dir[g]; m_last = g; m_pend[g] = 0;
            end
        end
        if (ovf_clr) m_ovf = '0;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] != m_level[i]) begin
                    if (pend_old[i] && i != g) m_ovf[i] = 1;
                    m_pend[i] = 1;
                    m_dir[i] = s2[i];
                end
            end
            m_level = s2;
        end
        m_h1 = m_h0;
        m_h0 = in_data;
        m_k++;
    endtask

    task automatic check_model();
        chk("model_valid", evt_valid, m_offer);
        chk("model_id", evt_id, m_id);
        chk("model_rising", evt_rising, m_rise);
        chk("model_tick", sample_tick, (m_k % DIV) == DIV - 1);
        chk("model_level", level, m_level);
        chk("model_ovf", ovf, m_ovf);
    endtask

    task automatic step();
        if (last_valid && evt_ready) obs.push_back('{id: last_id, rise: last_rise});
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        last_valid = evt_valid;
        last_id = evt_id;
        last_rise = evt_rising;
    endtask

    task automatic apply_reset();
        in_data = '0; evt_ready = 0; ovf_clr = 0;
        #2 rst_n = 0;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_rising", evt_rising, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tick", sample_tick, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        obs.delete();
    endtask

    task automatic expect_obs(input string name, input ev_t exp[$]);
        chk({name, "_count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < obs.size()) begin
                chk($sformatf("%s_id%0d", name, i), obs[i].id, exp[i].id);
                chk($sformatf("%s_rise%0d", name, i), obs[i].rise, exp[i].rise);
            end
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] din, input logic tick, input logic valid,
                                 input logic [1:0] id, input logic rise, input logic [3:0] lvl);
        return '{din: din, rdy: 1'b1, tick: tick, valid: valid, id: id, rise: rise, lvl: lvl};
    endfunction

    vec_t tbl[$];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        check_model();

        // Idle after reset, then channel 2 rises and falls 12 cycles later.
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 1, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 1, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h4, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h4, 0, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h4, 1, 0, 0, 0, 4'h0));
        tbl.push_back(mkv(4'h4, 0, 0, 0, 0, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 1, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 1, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 1, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h4, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h0, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h0, 0, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h0, 1, 0, 2, 1, 4'h4));
        tbl.push_back(mkv(4'h0, 0, 0, 2, 1, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 1, 2, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 2, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 1, 0, 2, 0, 4'h0));
        tbl.push_back(mkv(4'h0, 0, 0, 2, 0, 4'h0));
        for (int r = 0; r < tbl.size(); r++) begin
            in_data = tbl[r].din;
            evt_ready = tbl[r].rdy;
            step();
            chk($sformatf("tbl%0d_tick", r), sample_tick, tbl[r].tick);
            chk($sformatf("tbl%0d_valid", r), evt_valid, tbl[r].valid);
            chk($sformatf("tbl%0d_id", r), evt_id, tbl[r].id);
            chk($sformatf("tbl%0d_rise", r), evt_rising, tbl[r].rise);
            chk($sformatf("tbl%0d_level", r), level, tbl[r].lvl);
            chk($sformatf("tbl%0d_ovf", r), ovf, 0);
        end

        // Round-robin order over two batches.
        apply_reset();
        evt_ready = 1;
        in_data = 4'b1011;
        repeat (12) step();
        expect_obs("rr_a", '{'{0, 1}, '{1, 1}, '{3, 1}});
        obs.delete();
        in_data = 4'b0010;
        repeat (12) step();
        expect_obs("rr_b", '{'{0, 0}, '{3, 0}});

        // Backpressure with a coalesced change on channel 1.
        apply_reset();
        in_data = 4'b0010;
        repeat (4) step();
        in_data = 4'b0000;
        step();
        repeat (3) begin
            step();
            chk("stall_valid", evt_valid, 1);
            chk("stall_id", evt_id, 1);
            chk("stall_rise", evt_rising, 1);
        end
        chk("no_ovf_while_offered", ovf, 0);
        in_data = 4'b0010;
        repeat (4) begin
            step();
            chk("stall_valid", evt_valid, 1);
            chk("stall_id", evt_id, 1);
            chk("stall_rise", evt_rising, 1);
        end
        chk("ovf_set", ovf, 4'b0010);
        evt_ready = 1;
        repeat (6) step();
        expect_obs("coal", '{'{1, 1}, '{1, 1}});
        chk("ovf_sticky", ovf, 4'b0010);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("ovf_cleared", ovf, 0);

        // Channel 1 granted on the same edge its change is sampled.
        apply_reset();
        repeat (14) begin
            in_data = (m_k >= 4) ? 4'b0001 : 4'b0011;
            evt_ready = (m_k >= 6);
            step();
        end
        expect_obs("same_edge", '{'{0, 1}, '{1, 1}, '{1, 0}});
        chk("same_edge_ovf", ovf, 0);

        // Reset during an offer, then a glitch shorter than the sample period.
        apply_reset();
        in_data = 4'b0001;
        repeat (5) step();
        chk("pre_reset_valid", evt_valid, 1);
        apply_reset();
        in_data = 4'b0001;
        step();
        step();
        in_data = 4'b0000;
        repeat (12) step();
        chk("glitch_events", obs.size(), 0);

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) in_data = in_data ^ 4'($urandom);
            evt_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/input_event_scheduler.md
# input_event_scheduler

Samples N asynchronous digital inputs (buttons, robot contact/IR sensors) on a programmable clock-enable tick, detects level changes per channel, and queues one pending event per channel. A round-robin scheduler serialises the pending events onto a single valid/ready event channel consumed by the game logic. It sits between the board's raw input pins and the game control FSM, replacing ad-hoc per-input edge detection and free-running enables.

## Interface
- N_INPUTS, 4, number of input channels; legal range is 2 or more.
- SAMPLE_DIV, 50000, clock cycles per sample tick; legal range is 2 or more.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N_INPUTS  raw asynchronous inputs
- evt_ready  in  1  consumer accepts the event when high while evt_valid is high
- ovf_clr  in  1  single-cycle pulse; clears all ovf bits
- evt_valid  out  1  event offered
- evt_id  out  $clog2(N_INPUTS)  channel index of the offered event
- evt_rising  out  1  1 = 0→1 transition, 0 = 1→0 transition
- sample_tick  out  1  one-cycle strobe on the sampling edge
- level  out  N_INPUTS  last sampled (debounced-by-rate) input levels
- ovf  out  N_INPUTS  sticky per-channel "event coalesced" flags

## Operation
- **Synchroniser**: each in_data bit passes through 2 flops (sync1, sync2). All later logic uses sync2 only.
- **Prescaler**:
  - Counter of width $clog2(SAMPLE_DIV) counts 0..SAMPLE_DIV-1, then wraps to 0.
  - sample_tick = (count == SAMPLE_DIV-1). It is combinational from the counter and is high for exactly 1 cycle per period.
- **Sampling**: on a clock edge where sample_tick=1, for each channel i: level[i] <= sync2[i]. If sync2[i] != level[i] it is a change:
  - If pending[i] is clear: set pending[i] and store dir[i] <= sync2[i].
  - If pending[i] is already set: the events coalesce. dir[i] <= sync2[i] (latest direction wins) and ovf[i] <= 1.
- **Scheduler FSM** (2 states):
  - IDLE:
    - If pending is non-zero, grant the first set channel searching from last_grant+1 upward, modulo N_INPUTS.
    - On the grant: load evt_id <= g and evt_rising <= dir[g], clear pending[g], set last_grant <= g, and go to OFFER.
  - OFFER:
    - evt_valid=1. evt_id and evt_rising are held stable.
    - When evt_ready=1, go to IDLE.
- **Simultaneous grant and change on the same channel**: the set wins, so pending[g] stays 1 with the new dir. This is a new event, and ovf is not set.
- **Changes while a channel is offered**: they set pending normally. ovf is not set, because pending was cleared at the grant.
- **Overflow flags**: ovf bits clear only on ovf_clr or reset. If ovf_clr and a new overflow occur on the same edge, the set wins.
- **Level at reset**: level resets to 0. An input held high through reset produces a rising event at the first tick after its value reaches sync2.

## Timing
- **Reset values**: evt_valid=0, evt_id=0, evt_rising=0, level=0, ovf=0, pending=0, count=0, sync flops=0, FSM=IDLE, last_grant=N_INPUTS-1 (so channel 0 has first priority).
- **Reset mid-operation**: asserting rst_n low drops all outputs to their reset values asynchronously, including mid-OFFER. The offered event is discarded.
- **Input latency**: a change in in_data is visible in sync2 2 edges later. It is sampled at the next tick edge.
- **Tick to valid**: evt_valid rises 1 edge after the sampling edge (IDLE→OFFER), at the earliest.
- **Throughput**: at most 1 event per 2 cycles, because a handshake always returns to IDLE.
- **Aliasing**: input pulses shorter than SAMPLE_DIV cycles that fall between ticks are not seen. This is intended.
- **Handshake rules**:
  - evt_valid must not drop without evt_ready.
  - evt_ready while evt_valid is low is ignored.

## Structure
- **Shared package** (e.g. input_pkg), holding:
  - FSM state enum {IDLE, OFFER}
  - SYNC_STAGES=2
  - a helper function for the index width.
- **Sub-module**: one, rr_arbiter (N-bit request vector + last_grant → one-hot/indexed grant, valid flag). It is purely combinational and reusable by the motor-command mux.
- **Top-level contents**: the prescaler, synchroniser, per-channel pending/dir/ovf regs, and the FSM stay in the top module.

## Test plan
All scenarios use N_INPUTS=4 and SAMPLE_DIV=4.
1. **Reset behaviour**
   - Stimulus: release reset and drive in_data=0.
   - Required: all outputs are 0, sample_tick pulses every 4 cycles, and evt_valid never rises.
2. **Single channel rise then fall**
   - Stimulus: evt_ready=1. in_data[2] rises, then falls 12 cycles later.
   - Required: exactly two handshakes, (id=2, rising=1) then (id=2, rising=0), with evt_valid high 1 cycle each. level[2] tracks the input.
3. **Round-robin order**
   - Stimulus: channels 0, 1 and 3 change within one tick window, evt_ready=1.
   - Required: events are issued in order 0, 1, 3. A following batch on channels 0 and 3 issues 0 then 3.
4. **Backpressure and coalescing**
   - Stimulus: evt_ready=0. in_data[1] rises, falls at the next tick, and rises at the tick after that.
   - Required:
     - The offer stays at id=1, rising=1, stable, for the whole stall.
     - ovf[1]=1 after the third change.
     - Releasing evt_ready yields a second event id=1, rising=1.
     - An ovf_clr pulse then clears ovf[1].
5. **Same-edge grant and change**
   - Stimulus: a change on a channel lands on the same edge as that channel's grant.
   - Required: pending is re-set, the next event carries the new direction, and ovf stays 0.
6. **Asynchronous reset while offering**
   - Stimulus: assert rst_n low while evt_valid=1, and also inject a sub-tick glitch (2 cycles wide) on in_data[0].
   - Required: evt_valid drops immediately on reset. After reset, no event is produced for the glitch.
